// File: rtl/avalon_stream_accel.sv
// avalon_stream_accel: CSR-programmed memory walker. It reads LEN words from SRC, then either
// writes copy/add/xor results to DST or accumulates them into RESULT. DONE pulses at the end.
module avalon_stream_accel #(
    parameter int unsigned AVS_DATA_W = 32,
    parameter int unsigned AVS_ADDR_W = 4,
    parameter int unsigned AVM_DATA_W = 32,
    parameter int unsigned AVM_ADDR_W = 32,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                  csi_clock_clk,
    input  logic                  csi_clock_reset,
    input  logic [AVS_ADDR_W-1:0] avs_avalonslave_address,
    input  logic                  avs_avalonslave_read,
    input  logic                  avs_avalonslave_write,
    input  logic [AVS_DATA_W-1:0] avs_avalonslave_writedata,
    output logic [AVS_DATA_W-1:0] avs_avalonslave_readdata,
    output logic                  avs_avalonslave_waitrequest,
    output logic [AVM_ADDR_W-1:0] avm_avalonmaster_address,
    output logic                  avm_avalonmaster_read,
    output logic                  avm_avalonmaster_write,
    output logic [AVM_DATA_W-1:0] avm_avalonmaster_writedata,
    input  logic [AVM_DATA_W-1:0] avm_avalonmaster_readdata,
    input  logic                  avm_avalonmaster_waitrequest,
    output logic                  DONE
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StFin} state_e;

    localparam logic [AVS_ADDR_W-1:0] AddrCtrl   = AVS_ADDR_W'(0);
    localparam logic [AVS_ADDR_W-1:0] AddrStatus = AVS_ADDR_W'(1);
    localparam logic [AVS_ADDR_W-1:0] AddrSrc    = AVS_ADDR_W'(2);
    localparam logic [AVS_ADDR_W-1:0] AddrDst    = AVS_ADDR_W'(3);
    localparam logic [AVS_ADDR_W-1:0] AddrLen    = AVS_ADDR_W'(4);
    localparam logic [AVS_ADDR_W-1:0] AddrConst  = AVS_ADDR_W'(5);
    localparam logic [AVS_ADDR_W-1:0] AddrResult = AVS_ADDR_W'(6);
    localparam logic [AVS_ADDR_W-1:0] AddrCount  = AVS_ADDR_W'(7);

    localparam logic [1:0] ModeCopy = 2'd0;
    localparam logic [1:0] ModeAdd  = 2'd1;
    localparam logic [1:0] ModeXor  = 2'd2;
    localparam logic [1:0] ModeAcc  = 2'd3;

    localparam logic [AVM_ADDR_W-1:0] Step = AVM_ADDR_W'(AVM_DATA_W / 8);

    state_e                state_q, state_d;
    logic [AVM_ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [AVM_ADDR_W-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]      len_q, len_d, count_q, count_d;
    logic [AVM_DATA_W-1:0] const_q, const_d, result_q, result_d, wdata_q, wdata_d;
    logic [1:0]            mode_q, mode_d;
    logic                  abort_pend_q, abort_pend_d;
    logic                  done_sticky_q, done_sticky_d;
    logic                  aborted_q, aborted_d;

    logic                  busy, csr_wr, ctrl_wr, start, abort_req, abort_now;
    logic                  rd_ack, wr_ack, last;
    logic [LEN_W-1:0]      count_inc;
    logic                  unused_rd;

    assign unused_rd = avs_avalonslave_read;

    assign busy      = (state_q != StIdle);
    assign csr_wr    = avs_avalonslave_write;
    assign ctrl_wr   = csr_wr && (avs_avalonslave_address == AddrCtrl);
    // A start with a simultaneous abort in idle wins; abort is only latched mid-transfer.
    assign start     = ctrl_wr && avs_avalonslave_writedata[0] && !busy;
    assign abort_req = ctrl_wr && avs_avalonslave_writedata[3] &&
                       ((state_q == StRd) || (state_q == StWr));
    assign abort_now = abort_pend_q || abort_req;
    assign rd_ack    = (state_q == StRd) && !avm_avalonmaster_waitrequest;
    assign wr_ack    = (state_q == StWr) && !avm_avalonmaster_waitrequest;
    assign count_inc = count_q + LEN_W'(1);
    assign last      = (count_inc == len_q);

    // State register
    always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
        if (csi_clock_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a request only moves on once the fabric accepts it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (len_q != '0) ? StRd : StFin;
                end
            end
            StRd: begin
                if (rd_ack) begin
                    if (mode_q == ModeAcc) begin
                        state_d = (last || abort_now) ? StFin : StRd;
                    end else begin
                        state_d = StWr;
                    end
                end
            end
            StWr: begin
                if (wr_ack) begin
                    state_d = (last || abort_now) ? StFin : StRd;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Master-side outputs decoded from state so reset drops them immediately
    always_comb begin
        avm_avalonmaster_read    = (state_q == StRd);
        avm_avalonmaster_write   = (state_q == StWr);
        avm_avalonmaster_address = '0;
        if (state_q == StRd) begin
            avm_avalonmaster_address = src_ptr_q;
        end else if (state_q == StWr) begin
            avm_avalonmaster_address = dst_ptr_q;
        end
        DONE = (state_q == StFin);
    end

    assign avm_avalonmaster_writedata  = wdata_q;
    assign avs_avalonslave_waitrequest = 1'b0;

    // CSR updates, pointer walk and data processing
    always_comb begin
        src_d         = src_q;
        dst_d         = dst_q;
        len_d         = len_q;
        const_d       = const_q;
        src_ptr_d     = src_ptr_q;
        dst_ptr_d     = dst_ptr_q;
        count_d       = count_q;
        result_d      = result_q;
        wdata_d       = wdata_q;
        mode_d        = mode_q;
        abort_pend_d  = abort_pend_q;
        done_sticky_d = done_sticky_q;
        aborted_d     = aborted_q;

        if (csr_wr && !busy) begin
            case (avs_avalonslave_address)
                AddrSrc:   src_d   = AVM_ADDR_W'(avs_avalonslave_writedata);
                AddrDst:   dst_d   = AVM_ADDR_W'(avs_avalonslave_writedata);
                AddrLen:   len_d   = LEN_W'(avs_avalonslave_writedata);
                AddrConst: const_d = AVM_DATA_W'(avs_avalonslave_writedata);
                default: ;
            endcase
        end
        if (csr_wr && (avs_avalonslave_address == AddrStatus)) begin
            done_sticky_d = done_sticky_q & ~avs_avalonslave_writedata[1];
            aborted_d     = aborted_q & ~avs_avalonslave_writedata[2];
        end
        if (abort_req) begin
            abort_pend_d = 1'b1;
        end
        if (start) begin
            src_ptr_d = src_q;
            dst_ptr_d = dst_q;
            mode_d    = avs_avalonslave_writedata[2:1];
            count_d   = '0;
            result_d  = '0;
        end
        if (rd_ack) begin
            src_ptr_d = src_ptr_q + Step;
            unique case (mode_q)
                ModeCopy: wdata_d = avm_avalonmaster_readdata;
                ModeAdd:  wdata_d = avm_avalonmaster_readdata + const_q;
                ModeXor:  wdata_d = avm_avalonmaster_readdata ^ const_q;
                ModeAcc: begin
                    result_d = result_q + avm_avalonmaster_readdata;
                    count_d  = count_inc;
                end
                default: ;
            endcase
        end
        if (wr_ack) begin
            dst_ptr_d = dst_ptr_q + Step;
            count_d   = count_inc;
        end
        // Sticky flags set in FIN take priority over a same-cycle clear
        if (state_q == StFin) begin
            done_sticky_d = 1'b1;
            aborted_d     = aborted_q | abort_pend_q;
            abort_pend_d  = 1'b0;
        end
    end

    // Datapath and CSR registers
    always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
        if (csi_clock_reset) begin
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            const_q       <= '0;
            src_ptr_q     <= '0;
            dst_ptr_q     <= '0;
            count_q       <= '0;
            result_q      <= '0;
            wdata_q       <= '0;
            mode_q        <= '0;
            abort_pend_q  <= 1'b0;
            done_sticky_q <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            src_q         <= src_d;
            dst_q         <= dst_d;
            len_q         <= len_d;
            const_q       <= const_d;
            src_ptr_q     <= src_ptr_d;
            dst_ptr_q     <= dst_ptr_d;
            count_q       <= count_d;
            result_q      <= result_d;
            wdata_q       <= wdata_d;
            mode_q        <= mode_d;
            abort_pend_q  <= abort_pend_d;
            done_sticky_q <= done_sticky_d;
            aborted_q     <= aborted_d;
        end
    end

    // CSR read mux, combinational from address
    always_comb begin
        avs_avalonslave_readdata = '0;
        case (avs_avalonslave_address)
            AddrStatus: avs_avalonslave_readdata = AVS_DATA_W'({aborted_q, done_sticky_q, busy});
            AddrSrc:    avs_avalonslave_readdata = AVS_DATA_W'(src_q);
            AddrDst:    avs_avalonslave_readdata = AVS_DATA_W'(dst_q);
            AddrLen:    avs_avalonslave_readdata = AVS_DATA_W'(len_q);
            AddrConst:  avs_avalonslave_readdata = AVS_DATA_W'(const_q);
            AddrResult: avs_avalonslave_readdata = AVS_DATA_W'(result_q);
            AddrCount:  avs_avalonslave_readdata = AVS_DATA_W'(count_q);
            default:    avs_avalonslave_readdata = '0;
        endcase
    end

endmodule

// File: doc/avalon_stream_accel.md
Name: avalon_stream_accel

Overview:
- Parametrised successor to the single-function Avalon accelerator.
- A CPU programs an Avalon-MM slave CSR bank with source address, destination address, word count and mode.
- The block then walks memory through an Avalon-MM master and applies one of four operations: copy, add-constant, XOR-constant, or accumulate.
- It sits between the system interconnect and on-chip or SDRAM memory. DONE pulses on completion.

Parameters:
- AVS_DATA_W, 32, slave data width
- AVS_ADDR_W, 4, slave word address width (16 CSR slots)
- AVM_DATA_W, 32, master data width; processing width
- AVM_ADDR_W, 32, master byte address width
- LEN_W, 16, width of the word-count register

Ports:
- csi_clock_clk  in  1  single clock, all logic rising-edge
- csi_clock_reset  in  1  asynchronous, active-high reset
- avs_avalonslave_address  in  AVS_ADDR_W  CSR word address
- avs_avalonslave_read  in  1  CSR read strobe
- avs_avalonslave_write  in  1  CSR write strobe
- avs_avalonslave_writedata  in  AVS_DATA_W  CSR write data
- avs_avalonslave_readdata  out  AVS_DATA_W  CSR read data, combinational from address
- avs_avalonslave_waitrequest  out  1  held 0 (zero-wait slave)
- avm_avalonmaster_address  out  AVM_ADDR_W  byte address
- avm_avalonmaster_read  out  1  read request
- avm_avalonmaster_write  out  1  write request
- avm_avalonmaster_writedata  out  AVM_DATA_W  processed data
- avm_avalonmaster_readdata  in  AVM_DATA_W  valid in the cycle read is high and waitrequest is low
- avm_avalonmaster_waitrequest  in  1  fabric stall
- DONE  out  1  one-cycle completion pulse

Behaviour:
- CSR map (word address):
  - 0 CTRL (write-only):
    - bit0 START (self-clearing)
    - bits2:1 MODE: 0 copy, 1 add, 2 xor, 3 accumulate
    - bit3 ABORT (self-clearing)
  - 1 STATUS: bit0 BUSY (RO), bit1 DONE_STICKY (write 1 to clear), bit2 ABORTED (write 1 to clear)
  - 2 SRC, 3 DST, 4 LEN (low LEN_W bits), 5 CONST: all read/write
  - 6 RESULT: RO, accumulate sum
  - 7 COUNT: RO, words completed
  - Unmapped addresses read 0; writes to them are ignored.
- Reset values:
  - All CSRs 0.
  - FSM IDLE.
  - avm read, write and address 0; writedata 0.
  - DONE 0; avs waitrequest 0.
- FSM states: IDLE, RD, WR, FIN.
  - IDLE, START=1, LEN!=0: latch src_ptr=SRC, dst_ptr=DST, mode=MODE; clear COUNT and RESULT; go to RD.
  - IDLE, START=1, LEN=0: go straight to FIN. No bus traffic; COUNT stays 0.
  - RD: read=1, address=src_ptr. Hold address and read while waitrequest=1. In the cycle waitrequest=0, capture readdata and src_ptr += AVM_DATA_W/8.
    - Modes 0-2: go to WR. Writedata is data, data+CONST (mod 2^AVM_DATA_W) or data^CONST.
    - Mode 3: RESULT += data (mod 2^AVM_DATA_W) and COUNT++. Go to FIN if COUNT+1==LEN or abort is pending, else RD. No writes are issued.
  - WR: write=1, address=dst_ptr, writedata held stable. In the cycle waitrequest=0: dst_ptr += AVM_DATA_W/8, COUNT++. Go to FIN if last or abort pending, else RD.
  - FIN: DONE=1 for exactly one cycle; DONE_STICKY=1; ABORTED=1 if aborted; go to IDLE.
- Read and write are never asserted together. At most one transaction is outstanding.
- Throughput:
  - With waitrequest=0, one word takes 2 cycles (RD, WR) in modes 0-2 and 1 cycle in mode 3.
  - LEN words complete in 2*LEN+1 cycles from START, or LEN+1 in mode 3, counted to the DONE pulse.
- Pointers wrap modulo 2^AVM_ADDR_W. No error is flagged.
- While BUSY:
  - Writes to CTRL.START, MODE, SRC, DST, LEN and CONST are ignored.
  - STATUS write-1-clear still works.
  - Reads are always allowed; COUNT and RESULT show live values.
- ABORT while BUSY is latched as pending. The in-flight transaction must still complete, because the Avalon request is held until waitrequest=0. The FSM then goes to FIN.
- ABORT in IDLE has no effect.
- START and ABORT written in the same IDLE cycle: start wins, and the abort is discarded.
- A DONE_STICKY clear in the same cycle as FIN sets it: set wins.
- Reset asserted mid-transfer: read and write drop to 0 asynchronously and all state returns to reset values. No DONE pulse is issued.

Test Plan:
- SRC=0x100, DST=0x200, LEN=4, MODE=0; memory [0x100..0x10C] = 1,2,3,4; waitrequest=0 -> writes of 1,2,3,4 to 0x200,0x204,0x208,0x20C; DONE 9 cycles after START; COUNT=4; STATUS=0x2.
- MODE=1, CONST=0xFFFFFFFF, data 5 -> writes 4 (wrap). MODE=2, CONST=0xFF, data 0x0F -> writes 0xF0.
- MODE=3, LEN=3, data 0x80000000, 0x80000000, 7 -> no avm_write ever; RESULT=7; DONE at START+4.
- Random waitrequest stalls of 0-5 cycles on every transfer -> address, read, write and writedata held stable during every stall; final memory matches the no-stall run.
- LEN=0 START -> no read or write; DONE 1 cycle later; COUNT=0. ABORT written during the 2nd WR of LEN=8 with a 3-cycle stall -> that write completes; COUNT=2; STATUS=0x6.
- Reset pulse during RD with waitrequest=1 -> avm_read=0 immediately; all CSRs 0; no DONE. A subsequent START runs normally.
